npc_exec_ctrl: RTL and testbench

Multi-cycle sequencer for the npc core: pc register, decoder, alu and register file.
- Owns the pc and the single shared memory port.
- Fetches an instruction, holds it stable for decode/alu, optionally issues one load/store, then commits pc and the register-file write.
- Replaces the free-running pc+4 / always-write scheme with a handshaked, stall-capable flow.

---
 rtl/npc_pkg.sv | 31 +++
 rtl/npc_mem_wait_timer.sv | 53 +++++
 rtl/npc_exec_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_npc_exec_ctrl.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pkg
// Description : Shared types and constants for the npc execution sequencer:
//               FSM state encoding, reset pc default, memory bus field
//               widths and timeout counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MASK_W  = 4;
    localparam int TIMER_W = 8;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [3:0] {
        ST_RST_HOLD = 4'd0,
        ST_IF_REQ   = 4'd1,
        ST_IF_WAIT  = 4'd2,
        ST_EX       = 4'd3,
        ST_MEM_REQ  = 4'd4,
        ST_MEM_WAIT = 4'd5,
        ST_WB       = 4'd6,
        ST_HALT     = 4'd7,
        ST_ERR      = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/npc_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : npc_mem_wait_timer
// Description : Response timeout counter shared by the fetch and data wait
//               states. Cleared when a request is accepted, counts every
//               wait cycle, and flags the wait cycle in which the count
//               reaches TIMEOUT.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_clr         - request accepted; restart the count
//               i_inc         - a wait state is active this cycle
//               o_expired     - this wait cycle is the TIMEOUT-th one
// Revision    : 1.0 - initial release
// ============================================================================
module npc_mem_wait_timer
    import npc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    // count_q holds the number of wait cycles already completed, so the
    // cycle in which it equals TIMEOUT-1 is the TIMEOUT-th wait cycle.
    localparam logic [TIMER_W-1:0] C_LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    assign o_expired = i_inc && (count_q == C_LAST);

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && !o_expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/npc_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : npc_exec_ctrl
// Description : Multi-cycle sequencer for the npc core. Owns the pc and the
//               single memory port: fetch, execute, optional load/store,
//               then commit of pc and register-file write.
// Ports       : clk, rst                   - clock, async active-high reset
//               mem_req_* / mem_resp_*     - shared valid/ready memory port
//               inst, pc                   - latched instruction, current pc
//               dec_*, next_pc, mem_addr,
//               store_data, store_mask     - decoder / datapath inputs
//               rf_wen, wb_sel_mem,
//               load_data, retire          - write-back control
//               halted, bus_error          - terminal status flags
// Revision    : 1.0 - initial release
// ============================================================================
module npc_exec_ctrl
    import npc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned       TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              mem_resp_err,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    input  logic              dec_load,
    input  logic              dec_store,
    input  logic              dec_rf_wen,
    input  logic              dec_halt,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [MASK_W-1:0] store_mask,
    output logic              rf_wen,
    output logic              wb_sel_mem,
    output logic [DATA_W-1:0] load_data,
    output logic              retire,
    output logic              halted,
    output logic              bus_error
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] inst_q;
    logic [DATA_W-1:0] inst_d;
    logic [DATA_W-1:0] load_data_q;
    logic [DATA_W-1:0] load_data_d;

    logic w_req_fire;
    logic w_in_wait;
    logic w_resp_ok;
    logic w_resp_bad;
    logic w_timeout;

    assign w_req_fire = mem_req_valid && mem_req_ready;
    // Responses are only looked at while a wait state is active, so stray
    // or post-reset responses can never disturb the sequencer.
    assign w_in_wait  = (state_q == ST_IF_WAIT) || (state_q == ST_MEM_WAIT);
    assign w_resp_ok  = w_in_wait && mem_resp_valid && !mem_resp_err;
    assign w_resp_bad = w_in_wait && mem_resp_valid && mem_resp_err;

    npc_mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_req_fire),
        .i_inc     (w_in_wait),
        .o_expired (w_timeout)
    );

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RST_HOLD;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            load_data_q <= load_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A valid response takes priority over the timeout
    // firing in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST_HOLD: state_d = ST_IF_REQ;
            ST_IF_REQ:   if (w_req_fire) state_d = ST_IF_WAIT;
            ST_IF_WAIT: begin
                if (w_resp_ok)                     state_d = ST_EX;
                else if (w_resp_bad || w_timeout)  state_d = ST_ERR;
            end
            ST_EX: begin
                if (dec_halt)                      state_d = ST_HALT;
                else if (dec_load || dec_store)    state_d = ST_MEM_REQ;
                else                               state_d = ST_WB;
            end
            ST_MEM_REQ:  if (w_req_fire) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (w_resp_ok)                     state_d = ST_WB;
                else if (w_resp_bad || w_timeout)  state_d = ST_ERR;
            end
            ST_WB:       state_d = ST_IF_REQ;
            ST_HALT:     state_d = ST_HALT;
            ST_ERR:      state_d = ST_ERR;
            default:     state_d = ST_ERR;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        load_data_d = load_data_q;
        if (state_q == ST_WB) begin
            pc_d = next_pc;
        end
        if ((state_q == ST_IF_WAIT) && w_resp_ok) begin
            inst_d = mem_resp_rdata;
        end
        // Store responses carry no useful data and must not clobber the
        // last load value.
        if ((state_q == ST_MEM_WAIT) && w_resp_ok && dec_load) begin
            load_data_d = mem_resp_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Output logic. Request fields are pure functions of state and the
    // stable decode inputs, so they hold until the handshake completes.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_wen   = 1'b0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        rf_wen        = 1'b0;
        wb_sel_mem    = 1'b0;
        retire        = 1'b0;
        halted        = 1'b0;
        bus_error     = 1'b0;
        case (state_q)
            ST_IF_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = pc_q;
            end
            ST_EX: begin
                retire = dec_halt;
            end
            ST_MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = mem_addr;
                mem_req_wen   = dec_store;
                mem_req_wdata = store_data;
                mem_req_wmask = dec_store ? store_mask : '0;
            end
            ST_WB: begin
                rf_wen     = dec_rf_wen && !dec_store;
                wb_sel_mem = dec_load;
                retire     = 1'b1;
            end
            ST_HALT: halted    = 1'b1;
            ST_ERR:  bus_error = 1'b1;
            default: ;
        endcase
    end

    assign inst      = inst_q;
    assign pc        = pc_q;
    assign load_data = load_data_q;

endmodule
`default_nettype wire

// File: tb/tb_npc_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_exec_ctrl
// Description : Directed self-checking bench for npc_exec_ctrl. Inputs are
//               driven 1 time unit after the rising edge, outputs checked
//               2 time units after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        dec_load;
    logic        dec_store;
    logic        dec_rf_wen;
    logic        dec_halt;
    logic [31:0] next_pc;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [3:0]  store_mask;
    logic        rf_wen;
    logic        wb_sel_mem;
    logic [31:0] load_data;
    logic        retire;
    logic        halted;
    logic        bus_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    npc_exec_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err),
        .inst           (inst),
        .pc             (pc),
        .dec_load       (dec_load),
        .dec_store      (dec_store),
        .dec_rf_wen     (dec_rf_wen),
        .dec_halt       (dec_halt),
        .next_pc        (next_pc),
        .mem_addr       (mem_addr),
        .store_data     (store_data),
        .store_mask     (store_mask),
        .rf_wen         (rf_wen),
        .wb_sel_mem     (wb_sel_mem),
        .load_data      (load_data),
        .retire         (retire),
        .halted         (halted),
        .bus_error      (bus_error)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dec();
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_rf_wen = 1'b0;
        dec_halt   = 1'b0;
        next_pc    = '0;
        mem_addr   = '0;
        store_data = '0;
        store_mask = '0;
    endtask

    // From an IF_REQ check point: accept, respond next cycle; ends in EX (+1).
    task automatic do_fetch(input logic [31:0] word);
        mem_req_ready = 1'b1;
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = word;
        mem_resp_err   = 1'b0;
        cyc();
        mem_resp_valid = 1'b0;
    endtask

    // Ends at the check point of the first IF_REQ cycle after reset.
    task automatic do_reset();
        rst            = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        mem_resp_rdata = '0;
        clear_dec();
        #1;
        cyc();
        rst = 1'b0;
        cyc();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        mem_resp_rdata = '0;
        clear_dec();
        cyc(); cyc(); #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", mem_req_valid);
        end
        checks++;
        if (pc !== 32'h8000_0000) begin
            failures++; $display("FAIL reset_pc got=%h exp=80000000", pc);
        end
        checks++;
        if (inst !== 32'h0 || load_data !== 32'h0) begin
            failures++; $display("FAIL reset_regs inst=%h load_data=%h exp=0/0", inst, load_data);
        end
        checks++;
        if ({retire, rf_wen, wb_sel_mem, halted, bus_error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {retire, rf_wen, wb_sel_mem, halted, bus_error});
        end
        cyc();
        rst = 1'b0;          // this cycle is RST_HOLD
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL rst_hold_valid got=%b exp=0", mem_req_valid);
        end
        cyc(); #1;           // IF_REQ
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 ||
            mem_req_wen !== 1'b0 || mem_req_wmask !== 4'b0) begin
            failures++;
            $display("FAIL first_fetch valid=%b addr=%h wen=%b wmask=%b exp=1/80000000/0/0000",
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
        end
    endtask

    task automatic test_alu();
        cyc();                                   // IF_WAIT
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0050_0093;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL alu_if_wait_valid got=%b exp=0", mem_req_valid);
        end
        cyc();                                   // EX
        mem_resp_valid = 1'b0;
        dec_rf_wen = 1'b1; next_pc = 32'h8000_0004;
        #1;
        checks++;
        if (inst !== 32'h0050_0093 || retire !== 1'b0) begin
            failures++; $display("FAIL alu_ex inst=%h retire=%b exp=00500093/0", inst, retire);
        end
        cyc(); #1;                               // WB, 4th cycle
        checks++;
        if (rf_wen !== 1'b1 || retire !== 1'b1 || wb_sel_mem !== 1'b0) begin
            failures++;
            $display("FAIL alu_wb rf_wen=%b retire=%b wb_sel_mem=%b exp=1/1/0", rf_wen, retire, wb_sel_mem);
        end
        cyc(); clear_dec(); #1;                  // IF_REQ
        checks++;
        if (pc !== 32'h8000_0004 || mem_req_valid !== 1'b1 ||
            mem_req_addr !== 32'h8000_0004 || retire !== 1'b0) begin
            failures++;
            $display("FAIL alu_commit pc=%h valid=%b addr=%h retire=%b exp=80000004/1/80000004/0",
                     pc, mem_req_valid, mem_req_addr, retire);
        end
    endtask

    task automatic test_load();
        do_fetch(32'h0000_2083);                 // EX
        dec_load = 1'b1; dec_rf_wen = 1'b1;
        mem_addr = 32'h8000_1000; next_pc = 32'h8000_0008;
        #1;
        checks++;
        if (retire !== 1'b0 || mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL load_ex retire=%b valid=%b exp=0/0", retire, mem_req_valid);
        end
        cyc(); #1;                               // MEM_REQ
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_1000 ||
            mem_req_wen !== 1'b0 || mem_req_wmask !== 4'b0) begin
            failures++;
            $display("FAIL load_req valid=%b addr=%h wen=%b wmask=%b exp=1/80001000/0/0000",
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
        end
        cyc();                                   // MEM_WAIT
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
        cyc();                                   // WB
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (load_data !== 32'hDEAD_BEEF || wb_sel_mem !== 1'b1 ||
            rf_wen !== 1'b1 || retire !== 1'b1) begin
            failures++;
            $display("FAIL load_wb load_data=%h sel=%b rf_wen=%b retire=%b exp=deadbeef/1/1/1",
                     load_data, wb_sel_mem, rf_wen, retire);
        end
        cyc(); clear_dec(); #1;                  // IF_REQ
        checks++;
        if (pc !== 32'h8000_0008 || mem_req_addr !== 32'h8000_0008) begin
            failures++; $display("FAIL load_commit pc=%h addr=%h exp=80000008", pc, mem_req_addr);
        end
    endtask

    task automatic test_store();
        do_fetch(32'h0020_A023);                 // EX
        dec_store = 1'b1; dec_rf_wen = 1'b1;
        mem_addr = 32'h8000_1004; store_data = 32'h0000_1234; store_mask = 4'b0011;
        next_pc = 32'h8000_000C;
        cyc(); #1;                               // MEM_REQ
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1 || mem_req_wmask !== 4'b0011 ||
            mem_req_wdata !== 32'h0000_1234 || mem_req_addr !== 32'h8000_1004) begin
            failures++;
            $display("FAIL store_req valid=%b wen=%b wmask=%b wdata=%h addr=%h exp=1/1/0011/00001234/80001004",
                     mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_wdata, mem_req_addr);
        end
        cyc();                                   // MEM_WAIT
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
        cyc();                                   // WB
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (rf_wen !== 1'b0 || retire !== 1'b1 || wb_sel_mem !== 1'b0 ||
            load_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_wb rf_wen=%b retire=%b sel=%b load_data=%h exp=0/1/0/deadbeef",
                     rf_wen, retire, wb_sel_mem, load_data);
        end
        cyc(); clear_dec(); #1;                  // IF_REQ
        checks++;
        if (pc !== 32'h8000_000C) begin
            failures++; $display("FAIL store_commit pc=%h exp=8000000c", pc);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        int rcount;
        bad = 0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) cyc();
            #1;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_000C) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0 addr=%h", bad, mem_req_addr);
        end
        cyc();
        mem_req_ready = 1'b1;
        cyc();                                   // IF_WAIT
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus_error !== 1'b0 || mem_req_valid !== 1'b0 || retire !== 1'b0) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bp_wait bad_cycles=%0d exp=0", bad);
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0050_0093;
        cyc();                                   // EX
        mem_resp_valid = 1'b0;
        dec_rf_wen = 1'b1; next_pc = 32'h8000_0010;
        rcount = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (retire === 1'b1) rcount++;
            if (i < 2) cyc();
        end
        clear_dec();
        checks++;
        if (rcount != 1 || pc !== 32'h8000_0010 || bus_error !== 1'b0) begin
            failures++;
            $display("FAIL bp_retire retires=%0d pc=%h err=%b exp=1/80000010/0", rcount, pc, bus_error);
        end
    endtask

    // Response on the 255th wait cycle must win over the timeout.
    task automatic test_timeout_boundary();
        cyc();                                   // IF_WAIT cycle 1
        for (int i = 0; i < 254; i++) cyc();     // now wait cycle 255
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0010_0113;
        cyc();
        mem_resp_valid = 1'b0;
        dec_rf_wen = 1'b1; next_pc = 32'h8000_0014;
        #1;
        checks++;
        if (bus_error !== 1'b0 || inst !== 32'h0010_0113) begin
            failures++;
            $display("FAIL tmo_edge_accept err=%b inst=%h exp=0/00100113", bus_error, inst);
        end
        cyc(); cyc(); clear_dec(); #1;
        checks++;
        if (pc !== 32'h8000_0014) begin
            failures++; $display("FAIL tmo_edge_commit pc=%h exp=80000014", pc);
        end
    endtask

    task automatic test_timeout();
        int n;
        int bad;
        cyc();                                   // IF_WAIT cycle 1
        n = 0;
        #1;
        while (bus_error !== 1'b1 && n < 400) begin
            n++;
            cyc();
            #1;
        end
        checks++;
        if (n != 255 || bus_error !== 1'b1) begin
            failures++; $display("FAIL timeout_cycles got=%0d err=%b exp=255/1", n, bus_error);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req_valid !== 1'b0 || bus_error !== 1'b1 || pc !== 32'h8000_0014) bad++;
            cyc(); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL timeout_err_hold bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_err_resp();
        do_reset();
        cyc();                                   // IF_WAIT
        mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_resp_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (bus_error !== 1'b0) begin
            failures++; $display("FAIL err_resp_early got=%b exp=0", bus_error);
        end
        cyc();
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        #1;
        checks++;
        if (bus_error !== 1'b1 || inst !== 32'h0 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_resp err=%b inst=%h valid=%b exp=1/00000000/0", bus_error, inst, mem_req_valid);
        end
    endtask

    task automatic test_halt();
        int bad;
        do_reset();
        do_fetch(32'h0010_0073);                 // EX
        dec_halt = 1'b1; dec_load = 1'b1; next_pc = 32'h8000_0004;
        #1;
        checks++;
        if (retire !== 1'b1 || halted !== 1'b0) begin
            failures++; $display("FAIL halt_ex retire=%b halted=%b exp=1/0", retire, halted);
        end
        cyc(); #1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (halted !== 1'b1 || retire !== 1'b0 || mem_req_valid !== 1'b0 ||
                pc !== 32'h8000_0000) bad++;
            cyc(); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halt_hold bad_cycles=%0d halted=%b valid=%b pc=%h exp=0", bad, halted, mem_req_valid, pc);
        end
        clear_dec();
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_fetch(32'h0050_0093);                 // EX
        dec_rf_wen = 1'b1; next_pc = 32'h8000_0004;
        cyc(); cyc(); clear_dec();               // IF_REQ
        do_fetch(32'h0000_2083);                 // EX
        dec_load = 1'b1; mem_addr = 32'h8000_1000; next_pc = 32'h8000_0008;
        cyc(); cyc();                            // MEM_WAIT
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== 32'h8000_0000 || mem_req_valid !== 1'b0 || inst !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset pc=%h valid=%b inst=%h exp=80000000/0/00000000", pc, mem_req_valid, inst);
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
        cyc();
        rst = 1'b0;                              // RST_HOLD with stray response
        cyc(); #1;                               // IF_REQ
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 ||
            load_data !== 32'h0 || inst !== 32'h0) begin
            failures++;
            $display("FAIL stray_resp valid=%b addr=%h load_data=%h inst=%h exp=1/80000000/0/0",
                     mem_req_valid, mem_req_addr, load_data, inst);
        end
        mem_resp_valid = 1'b0;
        clear_dec();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_backpressure();
        test_timeout_boundary();
        test_timeout();
        test_err_resp();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
